// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle LEGv8 data-memory stage.
// Resolves the branch select, checks and lane-maps sized loads/stores, drives
// a req/ack handshake to a WORD-wide bus, and stalls the pipe while busy.
module mem_access_unit #(
    parameter int WORD    = 64,
    parameter int TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        size,
    input  logic              signed_load,
    input  logic [WORD-1:0]   address,
    input  logic [WORD-1:0]   write_data,
    input  logic              branch,
    input  logic              branch_if_zero,
    input  logic              branch_if_not_zero,
    input  logic              zero,
    output logic              pc_src,
    output logic              stall,
    output logic              done,
    output logic              fault,
    output logic [WORD-1:0]   read_data,
    output logic              bus_req,
    output logic              bus_we,
    output logic [WORD-1:0]   bus_addr,
    output logic [WORD-1:0]   bus_wdata,
    output logic [WORD/8-1:0] bus_be,
    input  logic              bus_ack,
    input  logic [WORD-1:0]   bus_rdata
);
    localparam int NB  = WORD / 8;
    localparam int LOG = $clog2(NB);
    localparam int TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_FAULT} state_t;

    state_t          state_q, state_d;
    logic [WORD-1:0] read_data_q, read_data_d;
    logic            bus_req_q, bus_req_d;
    logic            bus_we_q, bus_we_d;
    logic [WORD-1:0] bus_addr_q, bus_addr_d;
    logic [WORD-1:0] bus_wdata_q, bus_wdata_d;
    logic [NB-1:0]   bus_be_q, bus_be_d;
    logic            done_q, done_d;
    logic            fault_q, fault_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic [LOG-1:0]  off_q, off_d;
    logic [1:0]      size_q, size_d;
    logic            sgn_q, sgn_d;

    // Request-side decode: legality checks and store lane placement.
    logic [LOG-1:0]  req_off;
    logic [WORD-1:0] req_mask, req_wlane;
    logic [NB-1:0]   req_be;
    logic            req_aligned, req_oversize, req_any;

    // Load-side decode: pick the addressed field out of the bus word and extend.
    logic [WORD-1:0] ld_shift, ld_mask, ld_ext;
    logic            ld_msb;

    // Branch select is pure decode, independent of the access FSM.
    assign pc_src = branch | (branch_if_zero & zero) | (branch_if_not_zero & ~zero);

    // Stall while a request is being accepted or the bus is outstanding.
    assign stall = ((state_q == S_IDLE) & (mem_read | mem_write)) | (state_q == S_REQ);

    assign read_data = read_data_q;
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_be    = bus_be_q;
    assign done      = done_q;
    assign fault     = fault_q;

    // Decode the incoming request: offset, size mask, byte enables, checks.
    always_comb begin
        req_any  = mem_read | mem_write;
        req_off  = address[LOG-1:0];
        req_mask = '0;
        for (int i = 0; i < WORD; i++) req_mask[i] = (i < (8 << size));
        req_be = '0;
        for (int i = 0; i < NB; i++)
            req_be[i] = (i >= int'(req_off)) && (i < int'(req_off) + (1 << size));
        req_wlane    = (write_data & req_mask) << {req_off, 3'b000};
        req_oversize = int'(size) > LOG;
        case (size)
            2'd0:    req_aligned = 1'b1;
            2'd1:    req_aligned = ~address[0];
            2'd2:    req_aligned = (address[1:0] == 2'b00);
            default: req_aligned = (address[2:0] == 3'b000);
        endcase
    end

    // Extract the latched-size field from the returned bus word and extend it.
    always_comb begin
        ld_shift = bus_rdata >> {off_q, 3'b000};
        ld_mask  = '0;
        for (int i = 0; i < WORD; i++) ld_mask[i] = (i < (8 << size_q));
        case (size_q)
            2'd0:    ld_msb = ld_shift[7];
            2'd1:    ld_msb = ld_shift[15];
            2'd2:    ld_msb = ld_shift[31];
            default: ld_msb = ld_shift[WORD-1];
        endcase
        ld_ext = (ld_shift & ld_mask) | ((sgn_q && ld_msb) ? ~ld_mask : '0);
    end

    // Next-state and next-output logic for the access FSM.
    always_comb begin
        state_d     = state_q;
        read_data_d = read_data_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        cnt_d       = cnt_q;
        off_d       = off_q;
        size_d      = size_q;
        sgn_d       = sgn_q;
        done_d      = 1'b0;
        fault_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_any) begin
                    if (req_oversize || !req_aligned) begin
                        state_d = S_FAULT;
                        fault_d = 1'b1;
                    end else begin
                        // Both strobes high resolves to a write.
                        state_d     = S_REQ;
                        bus_req_d   = 1'b1;
                        bus_we_d    = mem_write;
                        bus_addr_d  = {address[WORD-1:LOG], {LOG{1'b0}}};
                        bus_wdata_d = mem_write ? req_wlane : '0;
                        bus_be_d    = mem_write ? req_be : '0;
                        off_d       = req_off;
                        size_d      = size;
                        sgn_d       = signed_load;
                        cnt_d       = '0;
                    end
                end
            end
            S_REQ: begin
                if (bus_ack) begin
                    // Ack beats a timeout that expires in the same cycle.
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = '0;
                    bus_wdata_d = '0;
                    bus_be_d    = '0;
                    if (!bus_we_q) read_data_d = ld_ext;
                end else if ((TIMEOUT != 0) && (int'(cnt_q) + 1 == TIMEOUT)) begin
                    state_d     = S_FAULT;
                    fault_d     = 1'b1;
                    bus_req_d   = 1'b0;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = '0;
                    bus_wdata_d = '0;
                    bus_be_d    = '0;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            // Requests seen while retiring belong to the current instruction.
            S_DONE:  state_d = S_IDLE;
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Register FSM state, bus outputs, pulses and latched access attributes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            read_data_q <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            cnt_q       <= '0;
            off_q       <= '0;
            size_q      <= '0;
            sgn_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            read_data_q <= read_data_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            cnt_q       <= cnt_d;
            off_q       <= off_d;
            size_q      <= size_d;
            sgn_q       <= sgn_d;
        end
    end
endmodule
